dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter CPU_PRIO, default 1: 1 = CPU wins every conflict; 0 = round-robin on conflict.
REQ-002 Parameter MEM_WORDS, default 3072: number of valid data-memory words.
REQ-003 Reset is rst, synchronous, active-high; clock is clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 c_req/c_we  in  1 each  CPU single-word request and write flag.
REQ-007 c_addr/c_wdata/c_pc  in  32 each  CPU byte address, write data and PC for trace.
REQ-008 c_gnt  out  1  CPU access issued this cycle.
REQ-009 c_rdata/c_rvalid  out  32/1  CPU read data, valid one cycle after a granted read.
REQ-010 d_req/d_we  in  1 each  DMA burst request and write flag.
REQ-011 d_addr/d_wdata  in  32 each  DMA burst base byte address and per-beat write data.
REQ-012 d_len  in  4  burst length minus 1 (1..16 beats).
REQ-013 d_gnt  out  1  DMA beat issued this cycle; d_wdata consumed this cycle.
REQ-014 d_rdata/d_rvalid/d_done  out  32/1/1  DMA read data, its valid flag, and burst-complete pulse.
REQ-015 m_addr/m_wd/m_pc  out  32 each  memory address, write data and trace PC.
REQ-016 m_wr  out  1  memory write strobe; memory commits on the rising clk edge.
REQ-017 m_rd  in  32  combinational memory read data.

Function
REQ-018 FSM states SHALL be IDLE and BURST.
REQ-019 In IDLE, c_req SHALL be granted in the same cycle: c_gnt=1, m_* driven from c_*, m_wr=c_we.
REQ-020 In IDLE, d_req without a CPU win SHALL latch base, we and len, issue beat 0 that cycle, and move to BURST if d_len>0.
REQ-021 Beat k SHALL access base+4k (32-bit add, low two bits forwarded unchanged); the beat counter is 4 bits.
REQ-022 In BURST, c_req SHALL steal the cycle when CPU_PRIO=1 or the last-served flag is DMA; the DMA beat stalls and the counter holds.
REQ-023 Round-robin last-served flag SHALL update only on a conflict cycle; with no conflict the sole requester is served.
REQ-024 Conflict in IDLE with CPU_PRIO=0 SHALL follow the last-served flag, which resets to DMA so the CPU wins first.
REQ-025 Granted reads SHALL register m_rd into c_rdata or d_rdata and pulse the matching rvalid on the next cycle; c_rdata and d_rdata otherwise hold their value.
REQ-026 On a beat with word index addr[31:2] >= MEM_WORDS, m_wr SHALL be suppressed and registered read data SHALL be 0; the beat still counts.
REQ-027 d_done SHALL pulse one cycle after the final beat is issued, coincident with the final d_rvalid for reads; the FSM then returns to IDLE.
REQ-028 d_req SHALL be ignored while in BURST; a new burst needs IDLE.
REQ-029 With no grant: m_wr=0, m_addr=0, m_wd=0, m_pc=0.
REQ-030 At most one of c_gnt and d_gnt SHALL be high in any cycle.
REQ-031 m_pc SHALL equal c_pc on CPU beats and 0 on DMA beats.

Reset
REQ-032 rst SHALL force IDLE, clear the beat counter and latches, set the last-served flag to DMA, and drive all outputs to 0.
REQ-033 rst during BURST SHALL abort the burst: no write in the reset cycle, no d_done.

Structure
REQ-034 State encodings, beat-counter width and MEM_WORDS default SHALL live in shared package dm_arb_pkg.
REQ-035 Conflict selection SHALL be one sub-module, dm_arb_pick (two requests plus last-served flag to one-hot grant); everything else is inline.

Verification
REQ-036 CPU write: c_req=1, c_we=1, addr 0x10, data 0xDEADBEEF; next cycle CPU read of 0x10 -> c_rvalid next cycle with 0xDEADBEEF.
REQ-037 DMA write burst: base 0x100, d_len=3, data 1..4 -> words 0x100..0x10C hold 1..4; d_done on cycle 5.
REQ-038 CPU_PRIO=1, CPU read in burst cycle 2 -> beat 2 delayed one cycle, d_done one cycle later, no beat skipped.
REQ-039 CPU_PRIO=0, both requesting continuously -> grants alternate CPU, DMA, CPU, DMA.
REQ-040 DMA write burst at base 0x2FFC with d_len=1 -> beat 0 written, beat 1 (0x3000) m_wr=0; rst asserted mid-burst -> no further m_wr and no d_done.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

    // Arbiter FSM: IDLE accepts new work, BURST walks the beats of a DMA burst
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } dm_state_t;

    // Beat counter width; a burst is 1..16 beats
    localparam int BEAT_W = 4;

    // Number of implemented data-memory words
    localparam int MEM_WORDS_DEF = 3072;

    // True when the word index of a byte address lies inside the implemented memory
    function automatic logic word_ok(input logic [31:0] addr, input int words);
        return ({2'b00, addr[31:2]} < $unsigned(words));
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// rtl/dm_arb_pick.sv - two-requester grant selection with round-robin or fixed CPU priority
module dm_arb_pick #(
    parameter int CPU_PRIO = 1
) (
    input  logic       c_req,
    input  logic       d_req,
    input  logic       last_dma,
    output logic [1:0] gnt
);

    // gnt[0] = CPU, gnt[1] = DMA; on a conflict the CPU wins under fixed
    // priority, otherwise whoever was not served at the last conflict wins
    always_comb begin
        gnt = 2'b00;
        if (c_req && d_req) begin
            if ((CPU_PRIO != 0) || last_dma) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (c_req) begin
            gnt = 2'b01;
        end else if (d_req) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - single-port data-memory arbiter between CPU word accesses and DMA bursts
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int CPU_PRIO  = 1,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [31:0] c_pc,
    output logic        c_gnt,
    output logic [31:0] c_rdata,
    output logic        c_rvalid,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_len,
    output logic        d_gnt,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_done,

    output logic [31:0] m_addr,
    output logic [31:0] m_wd,
    output logic [31:0] m_pc,
    output logic        m_wr,
    input  logic [31:0] m_rd
);

    dm_state_t         state;
    logic [31:0]       base_q;
    logic              we_q;
    logic [BEAT_W-1:0] len_q;
    logic [BEAT_W-1:0] cnt_q;
    logic              last_dma;

    logic              in_burst;
    logic              cpu_want;
    logic              dma_want;
    logic              conflict;
    logic [1:0]        gnt;
    logic [31:0]       dma_addr;
    logic              dma_we;
    logic [31:0]       acc_addr;
    logic              addr_ok;

    assign in_burst = (state == BURST);

    // Reset masks both requesters so every output is quiet in the reset cycle.
    // During a burst the DMA side always wants the port; d_req is only sampled in IDLE.
    assign cpu_want = ~rst & c_req;
    assign dma_want = ~rst & (in_burst | d_req);
    assign conflict = cpu_want & dma_want;

    dm_arb_pick #(
        .CPU_PRIO (CPU_PRIO)
    ) u_pick (
        .c_req    (cpu_want),
        .d_req    (dma_want),
        .last_dma (last_dma),
        .gnt      (gnt)
    );

    assign c_gnt = gnt[0];
    assign d_gnt = gnt[1];

    // Beat 0 comes straight from the request inputs; later beats from the latched base
    assign dma_addr = in_burst ? (base_q + 32'({cnt_q, 2'b00})) : d_addr;
    assign dma_we   = in_burst ? we_q : d_we;
    assign acc_addr = c_gnt ? c_addr : dma_addr;
    assign addr_ok  = word_ok(acc_addr, MEM_WORDS);

    // Memory port mux: the granted side drives the port, writes beyond the memory are dropped
    always_comb begin
        m_addr = 32'd0;
        m_wd   = 32'd0;
        m_pc   = 32'd0;
        m_wr   = 1'b0;
        if (c_gnt) begin
            m_addr = c_addr;
            m_wd   = c_wdata;
            m_pc   = c_pc;
            m_wr   = c_we & addr_ok;
        end else if (d_gnt) begin
            m_addr = dma_addr;
            m_wd   = d_wdata;
            m_wr   = dma_we & addr_ok;
        end
    end

    // Burst FSM: latch the burst on beat 0, advance only on issued beats, pulse done after the last
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= 32'd0;
            we_q     <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            last_dma <= 1'b1;
            d_done   <= 1'b0;
        end else begin
            d_done <= 1'b0;
            if (conflict) begin
                last_dma <= d_gnt;
            end
            if (d_gnt) begin
                if (!in_burst) begin
                    base_q <= d_addr;
                    we_q   <= d_we;
                    len_q  <= d_len;
                    if (d_len == '0) begin
                        d_done <= 1'b1;
                    end else begin
                        state <= BURST;
                        cnt_q <= BEAT_W'(1);
                    end
                end else if (cnt_q == len_q) begin
                    state  <= IDLE;
                    cnt_q  <= '0;
                    d_done <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + BEAT_W'(1);
                end
            end
        end
    end

    // Read return: capture memory data one cycle after a granted read, zero for unbacked words
    always_ff @(posedge clk) begin
        if (rst) begin
            c_rdata  <= 32'd0;
            c_rvalid <= 1'b0;
            d_rdata  <= 32'd0;
            d_rvalid <= 1'b0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            d_rvalid <= d_gnt & ~dma_we;
            if (c_gnt && !c_we) begin
                c_rdata <= addr_ok ? m_rd : 32'd0;
            end
            if (d_gnt && !dma_we) begin
                d_rdata <= addr_ok ? m_rd : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized and directed self-checking bench for dm_arbiter
module tb_dm_arbiter;

    localparam int MW = 3072;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, c_pc, d_addr, d_wdata;
    logic [3:0]  d_len;

    // index 0: CPU_PRIO=1, index 1: CPU_PRIO=0
    logic [1:0]  c_gnt_o, c_rvalid_o, d_gnt_o, d_rvalid_o, d_done_o, m_wr_o;
    logic [31:0] c_rdata_o [2];
    logic [31:0] d_rdata_o [2];
    logic [31:0] m_addr_o  [2];
    logic [31:0] m_wd_o    [2];
    logic [31:0] m_pc_o    [2];
    logic [31:0] m_rd_o    [2];

    logic [31:0] env_mem [2][4096];
    logic [31:0] ref_mem [2][4096];

    int vectors = 0;
    int miscompares = 0;

    // reference model state (transaction level)
    bit          act      [2];
    logic [31:0] b_base   [2];
    bit          b_we     [2];
    int          b_len    [2];
    int          b_k      [2];
    bit          cpu_turn [2];
    bit          e_crv    [2];
    bit          e_drv    [2];
    bit          e_done   [2];
    logic [31:0] e_crd    [2];
    logic [31:0] e_drd    [2];
    logic [15:0] hist_c   [2];

    dm_arbiter #(.CPU_PRIO(1), .MEM_WORDS(MW)) u_prio (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_pc(c_pc),
        .c_gnt(c_gnt_o[0]), .c_rdata(c_rdata_o[0]), .c_rvalid(c_rvalid_o[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_len(d_len),
        .d_gnt(d_gnt_o[0]), .d_rdata(d_rdata_o[0]), .d_rvalid(d_rvalid_o[0]), .d_done(d_done_o[0]),
        .m_addr(m_addr_o[0]), .m_wd(m_wd_o[0]), .m_pc(m_pc_o[0]), .m_wr(m_wr_o[0]), .m_rd(m_rd_o[0])
    );

    dm_arbiter #(.CPU_PRIO(0), .MEM_WORDS(MW)) u_rr (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_pc(c_pc),
        .c_gnt(c_gnt_o[1]), .c_rdata(c_rdata_o[1]), .c_rvalid(c_rvalid_o[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_len(d_len),
        .d_gnt(d_gnt_o[1]), .d_rdata(d_rdata_o[1]), .d_rvalid(d_rvalid_o[1]), .d_done(d_done_o[1]),
        .m_addr(m_addr_o[1]), .m_wd(m_wd_o[1]), .m_pc(m_pc_o[1]), .m_wr(m_wr_o[1]), .m_rd(m_rd_o[1])
    );

    // memory model: unbacked words return junk so the arbiter's zeroing is visible
    assign m_rd_o[0] = ((m_addr_o[0] >> 2) < MW) ? env_mem[0][m_addr_o[0][13:2]] : (32'hA5A5_0000 ^ m_addr_o[0]);
    assign m_rd_o[1] = ((m_addr_o[1] >> 2) < MW) ? env_mem[1][m_addr_o[1][13:2]] : (32'hA5A5_0000 ^ m_addr_o[1]);

    function automatic logic [31:0] init_val(input int w);
        return 32'hC0DE_0000 ^ 32'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // compare one instance against the model for the current cycle, then advance the model
    task automatic model_check(input int i);
        string       nm;
        bit          prio, dw, cg, dg, we, inr;
        logic [31:0] a, wd, pc, rv;
        nm   = (i == 0) ? "prio" : "rr";
        prio = (i == 0);
        chk({nm, ".c_rvalid"}, 32'(c_rvalid_o[i]), 32'(e_crv[i]));
        chk({nm, ".c_rdata"},  c_rdata_o[i], e_crd[i]);
        chk({nm, ".d_rvalid"}, 32'(d_rvalid_o[i]), 32'(e_drv[i]));
        chk({nm, ".d_rdata"},  d_rdata_o[i], e_drd[i]);
        chk({nm, ".d_done"},   32'(d_done_o[i]), 32'(e_done[i]));
        cg = 0; dg = 0; we = 0; a = 0; wd = 0; pc = 0;
        if (!rst) begin
            dw = act[i] || d_req;
            cg = c_req && (!dw || prio || cpu_turn[i]);
            dg = dw && !cg;
            if (c_req && dw) cpu_turn[i] = dg;
            if (cg) begin
                a = c_addr; wd = c_wdata; pc = c_pc; we = c_we;
            end else if (dg) begin
                if (!act[i]) begin
                    b_base[i] = d_addr; b_we[i] = d_we; b_len[i] = int'(d_len); b_k[i] = 0;
                end
                a = b_base[i] + 32'(b_k[i] * 4); wd = d_wdata; we = b_we[i];
            end
        end
        inr = ((a >> 2) < MW);
        hist_c[i] = {hist_c[i][14:0], c_gnt_o[i]};
        chk({nm, ".c_gnt"},  32'(c_gnt_o[i]), 32'(cg));
        chk({nm, ".d_gnt"},  32'(d_gnt_o[i]), 32'(dg));
        chk({nm, ".excl"},   32'(c_gnt_o[i] & d_gnt_o[i]), 32'd0);
        chk({nm, ".m_addr"}, m_addr_o[i], a);
        chk({nm, ".m_wd"},   m_wd_o[i], wd);
        chk({nm, ".m_pc"},   m_pc_o[i], pc);
        chk({nm, ".m_wr"},   32'(m_wr_o[i]), 32'(we && inr && (cg || dg)));
        if (rst) begin
            act[i] = 0; cpu_turn[i] = 1;
            e_crv[i] = 0; e_drv[i] = 0; e_done[i] = 0; e_crd[i] = 0; e_drd[i] = 0;
        end else begin
            rv = inr ? ref_mem[i][a[13:2]] : 32'd0;
            e_crv[i] = cg && !we;
            if (e_crv[i]) e_crd[i] = rv;
            e_drv[i] = dg && !we;
            if (e_drv[i]) e_drd[i] = rv;
            if ((cg || dg) && we && inr) ref_mem[i][a[13:2]] = wd;
            e_done[i] = 0;
            if (dg) begin
                if (b_k[i] == b_len[i]) begin
                    act[i] = 0; e_done[i] = 1;
                end else begin
                    act[i] = 1; b_k[i]++;
                end
            end
        end
    endtask

    // one clock: check at negedge, commit memory writes just after the rising edge
    task automatic step();
        logic        pw [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model_check(i);
            pw[i] = m_wr_o[i]; pa[i] = m_addr_o[i]; pd[i] = m_wd_o[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (pw[i]) env_mem[i][pa[i][13:2]] = pd[i];
        end
    endtask

    task automatic quiet();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_pc = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_len = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] w;
        if ($urandom_range(0, 3) == 0) w = 32'(MW - 4) + $urandom_range(0, 7);
        else                           w = $urandom_range(0, 31);
        return (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 4096; w++) begin
                env_mem[i][w] = init_val(w);
                ref_mem[i][w] = init_val(w);
            end
            act[i] = 0; cpu_turn[i] = 1; b_base[i] = 0; b_we[i] = 0; b_len[i] = 0; b_k[i] = 0;
            e_crv[i] = 0; e_drv[i] = 0; e_done[i] = 0; e_crd[i] = 0; e_drd[i] = 0; hist_c[i] = 0;
        end
        quiet();
        rst = 1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 0;

        // CPU write then read back
        c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF; c_pc = 32'h400;
        step();
        c_we = 0; c_pc = 32'h404;
        step();
        quiet();
        chk("t1.rvalid", 32'(c_rvalid_o[0]), 32'd1);
        chk("t1.rdata", c_rdata_o[0], 32'hDEADBEEF);
        step();

        // DMA write burst of four beats
        d_req = 1; d_we = 1; d_addr = 32'h100; d_len = 4'd3; d_wdata = 32'd1;
        step();
        d_req = 0;
        for (int k = 2; k <= 4; k++) begin
            d_wdata = 32'(k);
            step();
        end
        quiet();
        chk("t2.done", 32'(d_done_o[0]), 32'd1);
        step();
        for (int k = 0; k < 4; k++) chk("t2.mem", env_mem[0][12'h40 + 12'(k)], 32'(k + 1));

        // CPU read steals burst cycle 2
        d_req = 1; d_we = 0; d_addr = 32'h100; d_len = 4'd3;
        step();
        d_req = 0;
        step();
        c_req = 1; c_addr = 32'h10;
        step();
        c_req = 0;
        step();
        chk("t3.early_done", 32'(d_done_o[0]), 32'd0);
        step();
        quiet();
        chk("t3.done", 32'(d_done_o[0]), 32'd1);
        chk("t3.last", d_rdata_o[0], 32'd4);
        step();

        // both requesting continuously: round-robin alternates, fixed priority starves DMA
        rst = 1;
        step();
        rst = 0;
        c_req = 1; c_addr = 32'h10; d_req = 1; d_addr = 32'h100; d_len = 4'd3;
        for (int n = 0; n < 8; n++) step();
        chk("t4.rr_alt", 32'(hist_c[1][7:0]), 32'h AA);
        chk("t4.prio_cpu", 32'(hist_c[0][7:0]), 32'hFF);
        quiet();
        rst = 1;
        step();
        rst = 0;

        // burst crossing the end of memory, then a burst aborted by reset
        d_req = 1; d_we = 1; d_addr = 32'h2FFC; d_len = 4'd1; d_wdata = 32'h1111_1111;
        step();
        d_req = 0; d_wdata = 32'h2222_2222;
        step();
        quiet();
        step();
        chk("t5.inside", env_mem[0][12'hBFF], 32'h1111_1111);
        chk("t5.outside", env_mem[0][12'hC00], init_val(12'hC00));
        d_req = 1; d_we = 1; d_addr = 32'h200; d_len = 4'd7; d_wdata = 32'h5;
        step();
        d_req = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        quiet();
        step();
        step();
        chk("t5.abort", env_mem[0][12'h82], init_val(12'h82));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            c_req   = ($urandom_range(0, 9) < 4);
            c_we    = $urandom_range(0, 1) == 1;
            c_addr  = rnd_addr();
            c_wdata = $urandom;
            c_pc    = $urandom;
            d_req   = ($urandom_range(0, 9) < 3);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = rnd_addr();
            d_wdata = $urandom;
            d_len   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
